// File: rtl/mpu_collector_if.sv
// Handshake and register-file bus between the FMA array, the dispatcher and
// the MPU result collector. The master side is the producer/dispatcher view;
// the slave side is the collector.
interface mpu_collector_if #(
  parameter int FP               = 32,
  parameter int M                = 3,
  parameter int N                = 3,
  parameter int MATRIX_REGISTERS = 8
);
  localparam int AW = (MATRIX_REGISTERS > 1) ? $clog2(MATRIX_REGISTERS) : 1;
  localparam int MW = $clog2(M + 1);
  localparam int NW = $clog2(N + 1);
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic              start_in;
  logic [AW-1:0]     dest_addr_in;
  logic [MW-1:0]     m_in;
  logic [NW-1:0]     n_in;
  logic              result_valid_in;
  logic [FP-1:0]     result_in;
  logic [RW-1:0]     result_row_in;
  logic [CW-1:0]     result_col_in;
  logic              result_ready_out;
  logic              busy_out;
  logic              reg_write_en_out;
  logic [AW-1:0]     reg_addr_out;
  logic [M*N*FP-1:0] reg_data_out;
  logic              done_out;
  logic              error_out;

  modport master (
    output start_in, dest_addr_in, m_in, n_in,
    output result_valid_in, result_in, result_row_in, result_col_in,
    input  result_ready_out, busy_out, reg_write_en_out, reg_addr_out,
    input  reg_data_out, done_out, error_out
  );

  modport slave (
    input  start_in, dest_addr_in, m_in, n_in,
    input  result_valid_in, result_in, result_row_in, result_col_in,
    output result_ready_out, busy_out, reg_write_en_out, reg_addr_out,
    output reg_data_out, done_out, error_out
  );
endinterface

// File: rtl/mpu_collector.sv
// MPU result collector: gathers individually indexed FMA results, in any
// order, into an m x n matrix and issues one full-matrix register write.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | waiting for a start; illegal shapes are rejected here
//   S_COLLECT | accepting one result per cycle until m*n unique elements
//   S_WRITE   | single-cycle register-file write and done pulse
module mpu_collector #(
  parameter int FP               = 32,
  parameter int M                = 3,
  parameter int N                = 3,
  parameter int MATRIX_REGISTERS = 8
) (
  input logic           clk,
  input logic           rst,
  mpu_collector_if.slave bus
);
  localparam int AW    = (MATRIX_REGISTERS > 1) ? $clog2(MATRIX_REGISTERS) : 1;
  localparam int MW    = $clog2(M + 1);
  localparam int NW    = $clog2(N + 1);
  localparam int SLOTS = M * N;
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CNTW  = $clog2(SLOTS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [AW-1:0]       dest_q;
  logic [MW-1:0]       m_q;
  logic [NW-1:0]       n_q;
  logic [FP-1:0]       buf_q [SLOTS];
  logic [SLOTS-1:0]    mask_q;
  logic [CNTW-1:0]     count_q;
  logic [AW-1:0]       reg_addr_q;
  logic [SLOTS*FP-1:0] reg_data_q;
  logic                error_q;

  logic                start_legal;
  logic                accept;
  logic                in_range;
  logic                store;
  logic                last;
  logic                err_d;
  logic [SW-1:0]       slot;
  logic [CNTW-1:0]     target;
  logic [SLOTS*FP-1:0] data_d;

  // Decode the incoming start and result against the latched shape.
  always_comb begin
    start_legal = (bus.m_in != '0) && (32'(bus.m_in) <= 32'(M)) &&
                  (bus.n_in != '0) && (32'(bus.n_in) <= 32'(N));
    accept      = bus.result_valid_in && (state_q == S_COLLECT);
    in_range    = (32'(bus.result_row_in) < 32'(m_q)) &&
                  (32'(bus.result_col_in) < 32'(n_q));
    // Slot is only used when in_range holds, so truncation of illegal
    // indices is harmless.
    slot        = SW'(bus.result_row_in) * SW'(N) + SW'(bus.result_col_in);
    store       = accept && in_range && !mask_q[slot];
    target      = CNTW'(m_q) * CNTW'(n_q);
    last        = store && ((count_q + CNTW'(1)) == target);
    // Several simultaneous causes collapse into one pulse.
    err_d       = (bus.start_in && ((state_q != S_IDLE) || !start_legal)) ||
                  (accept && !store);
  end

  // Packed view of the buffer including the element being stored this
  // cycle, so the final write carries the last element too. Slot 0 is MSBs.
  always_comb begin
    data_d = '0;
    for (int s = 0; s < SLOTS; s++) begin
      data_d[(SLOTS-1-s)*FP +: FP] = (store && (slot == SW'(s))) ?
                                     bus.result_in : buf_q[s];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start_in && start_legal) state_d = S_COLLECT;
      S_COLLECT: if (last)                        state_d = S_WRITE;
      S_WRITE:                                    state_d = S_IDLE;
      default:                                    state_d = S_IDLE;
    endcase
  end

  // Shape latch, element buffer, mask, count and held write outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dest_q     <= '0;
      m_q        <= '0;
      n_q        <= '0;
      mask_q     <= '0;
      count_q    <= '0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      error_q    <= 1'b0;
      for (int s = 0; s < SLOTS; s++) buf_q[s] <= '0;
    end else begin
      error_q <= err_d;
      if ((state_q == S_IDLE) && bus.start_in && start_legal) begin
        dest_q  <= bus.dest_addr_in;
        m_q     <= bus.m_in;
        n_q     <= bus.n_in;
        mask_q  <= '0;
        count_q <= '0;
        for (int s = 0; s < SLOTS; s++) buf_q[s] <= '0;
      end else if (store) begin
        buf_q[slot]  <= bus.result_in;
        mask_q[slot] <= 1'b1;
        count_q      <= count_q + CNTW'(1);
      end
      // Address/data are captured once and then held until the next write.
      if (last) begin
        reg_addr_q <= dest_q;
        reg_data_q <= data_d;
      end
    end
  end

  // State-decoded strobes and handshake outputs.
  always_comb begin
    bus.result_ready_out = 1'b0;
    bus.busy_out         = 1'b0;
    bus.reg_write_en_out = 1'b0;
    bus.done_out         = 1'b0;
    case (state_q)
      S_COLLECT: begin
        bus.result_ready_out = 1'b1;
        bus.busy_out         = 1'b1;
      end
      S_WRITE: begin
        bus.busy_out         = 1'b1;
        bus.reg_write_en_out = 1'b1;
        bus.done_out         = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.reg_addr_out = reg_addr_q;
  assign bus.reg_data_out = reg_data_q;
  assign bus.error_out    = error_q;
endmodule

// File: tb/tb_mpu_collector.sv
// Self-checking bench for mpu_collector: scenario tasks plus a write
// scoreboard fed with expected matrices when each collection is started.
module tb_mpu_collector;
  localparam int FP    = 32;
  localparam int M     = 3;
  localparam int N     = 3;
  localparam int MR    = 8;
  localparam int SLOTS = M * N;

  typedef struct {
    logic [2:0]          addr;
    logic [SLOTS*FP-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;
  int   cyc = 0;
  wr_t  exp_q[$];
  logic [FP-1:0] model [SLOTS];

  always #5 clk = ~clk;

  mpu_collector_if #(.FP(FP), .M(M), .N(N), .MATRIX_REGISTERS(MR)) bus ();

  mpu_collector #(.FP(FP), .M(M), .N(N), .MATRIX_REGISTERS(MR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: every write must match the oldest expected matrix.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.reg_write_en_out || bus.done_out)) begin
        checks++;
        if (bus.done_out !== bus.reg_write_en_out) begin
          errors++;
          $display("FAIL done_strobe: done=%b write_en=%b, required equal", bus.done_out, bus.reg_write_en_out);
        end
        if (bus.reg_write_en_out) begin
          wr_count++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%0d, required no write", bus.reg_addr_out);
          end else begin
            e = exp_q.pop_front();
            if (bus.reg_addr_out !== e.addr || bus.reg_data_out !== e.data) begin
              errors++;
              $display("FAIL write_data: addr=%0d data=%h, required addr=%0d data=%h", bus.reg_addr_out, bus.reg_data_out, e.addr, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] fval(input int k);
    case (k)
      1: return 32'h3F800000;
      2: return 32'h40000000;
      3: return 32'h40400000;
      4: return 32'h40800000;
      5: return 32'h40A00000;
      6: return 32'h40C00000;
      7: return 32'h40E00000;
      8: return 32'h41000000;
      9: return 32'h41100000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SLOTS; s++) model[s] = '0;
  endtask

  task automatic model_put(input int r, input int c, input logic [31:0] v);
    model[r*N + c] = v;
  endtask

  function automatic logic [SLOTS*FP-1:0] model_pack();
    logic [SLOTS*FP-1:0] d;
    d = '0;
    for (int s = 0; s < SLOTS; s++) d[(SLOTS-1-s)*FP +: FP] = model[s];
    return d;
  endfunction

  task automatic push_expected(input logic [2:0] a);
    wr_t e;
    e.addr = a;
    e.data = model_pack();
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [2:0] d, input logic [1:0] m, input logic [1:0] n);
    bus.start_in     = 1'b1;
    bus.dest_addr_in = d;
    bus.m_in         = m;
    bus.n_in         = n;
    tick();
    bus.start_in     = 1'b0;
  endtask

  task automatic drive_result(input logic [1:0] r, input logic [1:0] c, input logic [31:0] v);
    bus.result_valid_in = 1'b1;
    bus.result_row_in   = r;
    bus.result_col_in   = c;
    bus.result_in       = v;
    tick();
    bus.result_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({bus.result_ready_out, bus.busy_out, bus.reg_write_en_out, bus.done_out, bus.error_out} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 00000", {bus.result_ready_out, bus.busy_out, bus.reg_write_en_out, bus.done_out, bus.error_out});
    end
    checks++;
    if (bus.reg_addr_out !== 3'd0 || bus.reg_data_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%0d data=%h, required 0", bus.reg_addr_out, bus.reg_data_out);
    end
    rst = 1'b0;
    tick();
    drive_start(3'd3, 2'd2, 2'd2);
    checks++;
    if (bus.result_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_collect_ready: got %b, required 1", bus.result_ready_out);
    end
    drive_result(2'd0, 2'd0, fval(1));
    drive_result(2'd0, 2'd1, fval(2));
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checks++;
    if ({bus.result_ready_out, bus.busy_out, bus.reg_write_en_out, bus.done_out} !== 4'b0) begin
      errors++;
      $display("FAIL midreset_strobes: got %b, required 0000", {bus.result_ready_out, bus.busy_out, bus.reg_write_en_out, bus.done_out});
    end
    checks++;
    if (bus.reg_data_out !== '0) begin
      errors++;
      $display("FAIL midreset_data: got %h, required 0", bus.reg_data_out);
    end
    repeat (3) tick();
    checks++;
    if (bus.busy_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: busy=%b, required 0", bus.busy_out);
    end
  endtask

  task automatic test_full_3x3();
    model_clear();
    for (int i = 0; i < 9; i++) model_put(i / 3, i % 3, fval(i + 1));
    push_expected(3'd5);
    drive_start(3'd5, 2'd3, 2'd3);
    checks++;
    if (bus.result_ready_out !== 1'b1 || bus.busy_out !== 1'b1) begin
      errors++;
      $display("FAIL full_collect: ready=%b busy=%b, required 1 1", bus.result_ready_out, bus.busy_out);
    end
    for (int i = 0; i < 9; i++) begin
      bus.result_valid_in = 1'b1;
      bus.result_row_in   = 2'(i / 3);
      bus.result_col_in   = 2'(i % 3);
      bus.result_in       = fval(i + 1);
      tick();
      if (i == 7) begin
        checks++;
        if (bus.reg_write_en_out !== 1'b0) begin
          errors++;
          $display("FAIL full_early_write: write_en=%b after 8 results, required 0", bus.reg_write_en_out);
        end
      end
    end
    bus.result_valid_in = 1'b0;
    checks++;
    if (bus.reg_write_en_out !== 1'b1 || bus.done_out !== 1'b1 || bus.result_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL full_write_timing: we=%b done=%b ready=%b, required 1 1 0", bus.reg_write_en_out, bus.done_out, bus.result_ready_out);
    end
    checks++;
    if (bus.reg_data_out[SLOTS*FP-1 -: FP] !== 32'h3F800000 || bus.reg_data_out[FP-1:0] !== 32'h41100000) begin
      errors++;
      $display("FAIL full_slots: slot0=%h slot8=%h, required 3f800000 41100000", bus.reg_data_out[SLOTS*FP-1 -: FP], bus.reg_data_out[FP-1:0]);
    end
    tick();
    checks++;
    if (bus.busy_out !== 1'b0 || bus.reg_write_en_out !== 1'b0 || bus.reg_addr_out !== 3'd5 || bus.reg_data_out !== model_pack()) begin
      errors++;
      $display("FAIL full_hold: busy=%b we=%b addr=%0d data=%h, required 0 0 5 held", bus.busy_out, bus.reg_write_en_out, bus.reg_addr_out, bus.reg_data_out);
    end
  endtask

  task automatic test_out_of_order();
    model_clear();
    model_put(0, 0, fval(1));
    model_put(0, 1, fval(2));
    model_put(1, 0, fval(3));
    model_put(1, 1, fval(4));
    push_expected(3'd6);
    drive_start(3'd6, 2'd2, 2'd2);
    drive_result(2'd1, 2'd1, fval(4));
    drive_result(2'd0, 2'd0, fval(1));
    drive_result(2'd1, 2'd0, fval(3));
    checks++;
    if (bus.reg_write_en_out !== 1'b0 || bus.error_out !== 1'b0) begin
      errors++;
      $display("FAIL ooo_partial: we=%b err=%b, required 0 0", bus.reg_write_en_out, bus.error_out);
    end
    drive_result(2'd0, 2'd1, fval(2));
    checks++;
    if (bus.reg_write_en_out !== 1'b1 || bus.reg_addr_out !== 3'd6) begin
      errors++;
      $display("FAIL ooo_write: we=%b addr=%0d, required 1 6", bus.reg_write_en_out, bus.reg_addr_out);
    end
    tick();
  endtask

  task automatic test_dup_oor();
    model_clear();
    model_put(0, 0, fval(1));
    model_put(0, 1, fval(2));
    model_put(1, 0, fval(3));
    model_put(1, 1, fval(4));
    push_expected(3'd1);
    drive_start(3'd1, 2'd2, 2'd2);
    drive_result(2'd0, 2'd0, fval(1));
    drive_result(2'd0, 2'd0, fval(7));
    checks++;
    if (bus.error_out !== 1'b1) begin
      errors++;
      $display("FAIL dup_error: err=%b, required 1", bus.error_out);
    end
    drive_result(2'd2, 2'd0, fval(5));
    checks++;
    if (bus.error_out !== 1'b1) begin
      errors++;
      $display("FAIL oor_error: err=%b, required 1", bus.error_out);
    end
    drive_result(2'd0, 2'd1, fval(2));
    checks++;
    if (bus.error_out !== 1'b0 || bus.reg_write_en_out !== 1'b0) begin
      errors++;
      $display("FAIL dup_count: err=%b we=%b after 2 unique, required 0 0", bus.error_out, bus.reg_write_en_out);
    end
    drive_result(2'd1, 2'd0, fval(3));
    checks++;
    if (bus.reg_write_en_out !== 1'b0) begin
      errors++;
      $display("FAIL dup_early_write: we=%b after 3 unique, required 0", bus.reg_write_en_out);
    end
    drive_result(2'd1, 2'd1, fval(4));
    checks++;
    if (bus.reg_write_en_out !== 1'b1) begin
      errors++;
      $display("FAIL dup_complete: we=%b after 4 unique, required 1", bus.reg_write_en_out);
    end
    tick();
  endtask

  task automatic test_illegal_start();
    drive_start(3'd4, 2'd0, 2'd2);
    checks++;
    if (bus.error_out !== 1'b1 || bus.busy_out !== 1'b0 || bus.result_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL start_m0: err=%b busy=%b ready=%b, required 1 0 0", bus.error_out, bus.busy_out, bus.result_ready_out);
    end
    tick();
    checks++;
    if (bus.error_out !== 1'b0) begin
      errors++;
      $display("FAIL error_single_pulse: err=%b, required 0", bus.error_out);
    end
    drive_start(3'd4, 2'd2, 2'd0);
    checks++;
    if (bus.error_out !== 1'b1 || bus.busy_out !== 1'b0) begin
      errors++;
      $display("FAIL start_n0: err=%b busy=%b, required 1 0", bus.error_out, bus.busy_out);
    end
    model_clear();
    model_put(0, 0, fval(5));
    model_put(0, 1, fval(6));
    push_expected(3'd7);
    drive_start(3'd7, 2'd1, 2'd2);
    checks++;
    if (bus.result_ready_out !== 1'b1 || bus.error_out !== 1'b0) begin
      errors++;
      $display("FAIL start_legal: ready=%b err=%b, required 1 0", bus.result_ready_out, bus.error_out);
    end
    drive_start(3'd2, 2'd3, 2'd3);
    checks++;
    if (bus.error_out !== 1'b1 || bus.result_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL start_in_collect: err=%b ready=%b, required 1 1", bus.error_out, bus.result_ready_out);
    end
    drive_result(2'd0, 2'd0, fval(5));
    drive_result(2'd0, 2'd1, fval(6));
    checks++;
    if (bus.reg_write_en_out !== 1'b1 || bus.reg_addr_out !== 3'd7) begin
      errors++;
      $display("FAIL start_ignored_dest: we=%b addr=%0d, required 1 7", bus.reg_write_en_out, bus.reg_addr_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int ts;
    model_clear();
    model_put(0, 0, fval(9));
    push_expected(3'd3);
    model_clear();
    model_put(0, 0, fval(2));
    push_expected(3'd4);
    drive_start(3'd3, 2'd1, 2'd1);
    drive_result(2'd0, 2'd0, fval(9));
    checks++;
    if (bus.reg_write_en_out !== 1'b1 || bus.reg_addr_out !== 3'd3) begin
      errors++;
      $display("FAIL b2b_first: we=%b addr=%0d, required 1 3", bus.reg_write_en_out, bus.reg_addr_out);
    end
    tick();
    checks++;
    if (bus.busy_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b, required 0", bus.busy_out);
    end
    ts = cyc;
    drive_start(3'd4, 2'd1, 2'd1);
    checks++;
    if (bus.result_ready_out !== 1'b1 || bus.error_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start: ready=%b err=%b, required 1 0", bus.result_ready_out, bus.error_out);
    end
    drive_result(2'd0, 2'd0, fval(2));
    // Start cycle, collect cycle, write cycle.
    checks++;
    if (bus.reg_write_en_out !== 1'b1 || bus.reg_addr_out !== 3'd4 || (cyc - ts + 1) != 3) begin
      errors++;
      $display("FAIL b2b_second: we=%b addr=%0d latency=%0d, required 1 4 3", bus.reg_write_en_out, bus.reg_addr_out, cyc - ts + 1);
    end
    tick();
  endtask

  initial begin
    bus.start_in        = 1'b0;
    bus.dest_addr_in    = '0;
    bus.m_in            = '0;
    bus.n_in            = '0;
    bus.result_valid_in = 1'b0;
    bus.result_in       = '0;
    bus.result_row_in   = '0;
    bus.result_col_in   = '0;
    test_reset();
    test_full_3x3();
    test_out_of_order();
    test_dup_oor();
    test_illegal_start();
    test_back_to_back();
    repeat (3) tick();
    checks++;
    if (wr_count != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL write_total: writes=%0d pending=%0d, required 6 0", wr_count, exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mpu_collector.md
# mpu_collector

Result collector for the MPU multiply path. It sits downstream of the FMA array and upstream of the matrix register file. It accepts individually indexed single-precision results, which may arrive in any order, and assembles them into an M×N result matrix. Once every expected element has arrived, it issues one full-matrix write to the register file at the latched destination address.

## Interface

**Parameters**
- FP, 32: floating-point word width.
- M, 3: maximum matrix rows.
- N, 3: maximum matrix columns.
- MATRIX_REGISTERS, 8: register file depth. Address width is $clog2(MATRIX_REGISTERS).

**Ports**
- clk  in  1  single clock. All logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start_in  in  1  dispatcher request to begin collecting a new result matrix.
- dest_addr_in  in  $clog2(MATRIX_REGISTERS)  destination register; sampled with start_in.
- m_in  in  $clog2(M+1)  result rows; sampled with start_in. Legal range 1..M.
- n_in  in  $clog2(N+1)  result columns; sampled with start_in. Legal range 1..N.
- result_valid_in  in  1  FMA result present.
- result_in  in  FP  FMA result (float_sp).
- result_row_in  in  $clog2(M)  row index of result_in.
- result_col_in  in  $clog2(N)  column index of result_in.
- result_ready_out  out  1  collector can accept a result this cycle.
- busy_out  out  1  a collection is in progress.
- reg_write_en_out  out  1  register file write strobe, one cycle.
- reg_addr_out  out  $clog2(MATRIX_REGISTERS)  write address.
- reg_data_out  out  M*N*FP  packed matrix. Element [r][c] is slot r*N+c; slot 0 occupies the MSBs.
- done_out  out  1  one-cycle completion pulse, coincident with reg_write_en_out.
- error_out  out  1  one-cycle protocol error pulse.

## Operation

**States:** IDLE, COLLECT, WRITE.

**IDLE**
- result_ready_out=0, busy_out=0.
- On start_in with legal m_in/n_in:
  - latch dest_addr_in, m_in, n_in;
  - clear the element buffer to 0, the received mask (M*N bits) and the element count;
  - go to COLLECT.
- On start_in with m_in or n_in equal to 0, or greater than M/N: pulse error_out, stay IDLE.

**COLLECT**
- result_ready_out=1, busy_out=1.
- A result is accepted when result_valid_in && result_ready_out.
- Index out of range (row ≥ latched m, or col ≥ latched n): drop the result, pulse error_out.
- Mask bit already set (duplicate): drop the result, keep the first value, pulse error_out.
- Otherwise:
  - store result_in in slot row*N+col;
  - set the mask bit;
  - increment the count.
- When the accepted element makes count == m*n, go to WRITE.

**WRITE**
- result_ready_out=0, busy_out=1.
- Assert reg_write_en_out and done_out for exactly one cycle, with reg_addr_out = latched dest and reg_data_out = buffer.
- Slots outside the m×n region are 0.
- Next state is IDLE.

**start_in outside IDLE** (COLLECT or WRITE): ignored; pulse error_out; the latched parameters are unchanged.

**Results outside COLLECT:** result_valid_in is not accepted, because ready is low. The producer must hold the result until ready is high.

**Error pulses:** error_out is a single pulse per offending cycle. Several simultaneous error causes still produce one pulse.

## Timing

- **Reset:**
  - state IDLE;
  - result_ready_out, busy_out, reg_write_en_out, done_out and error_out all 0;
  - reg_addr_out 0, reg_data_out 0;
  - buffer, mask and count cleared.
- **Reset mid-collection:** abandons the collection with no write and no done pulse. Behaviour is identical to power-on reset.
- **start_in to COLLECT:** start_in sampled at edge t gives COLLECT (ready=1) in cycle t+1.
- **Last element to write:** the last element accepted at edge t gives reg_write_en_out/done_out high in cycle t+1. IDLE follows in cycle t+2.
- **Minimum transaction:** for a 1×1 result, start to write is 3 cycles.
- **Throughput:** one result per cycle in COLLECT.
- **Back-to-back matrices:** the next start_in is accepted in the first IDLE cycle after WRITE.
- **Output stability:** reg_addr_out and reg_data_out hold their last values outside WRITE. Only reg_write_en_out qualifies them.

## Test plan

- **Reset:** rst held 2 cycles mid-COLLECT → all strobes 0, busy_out=0, no write issued, buffer 0.
- **Full 3×3 in order:** start(dest=5, m=3, n=3), then 9 results 1.0..9.0 row-major, one per cycle → single write to addr 5. Slot 0 = 0x3F800000, slot 8 = 0x41100000. done_out is high one cycle after the 9th accept.
- **2×2 out of order:** indices (1,1), (0,0), (1,0), (0,1) with values 4.0, 1.0, 3.0, 2.0 → slots 0, 1, 3, 4 = 1.0, 2.0, 3.0, 4.0; other slots 0; write to the latched dest.
- **Duplicate and out-of-range:** 2×2 collection with (0,0)=1.0, then (0,0)=7.0, then (2,0) → two error_out pulses, slot 0 stays 1.0, completion still needs 4 unique elements.
- **Illegal starts:** start with m=0 → error pulse, remains IDLE. start_in during COLLECT with dest=2 → error pulse, write goes to the originally latched dest.
- **Back-to-back 1×1:** start, one result, then start in the first IDLE cycle → two writes, the second 3 cycles after its start.
